// File: rtl/hazard_ctrl_if.sv
// Pipeline-register side signals seen by the hazard controller.
// master = pipeline datapath, slave = hazard_ctrl.
interface hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic [REG_AW-1:0] IF_ID_Rs, IF_ID_Rt;
  logic [REG_AW-1:0] ID_EX_Rs, ID_EX_Rt, ID_EX_Rd;
  logic              ID_EX_memRd;
  logic [REG_AW-1:0] EX_MEM_Rd, MEM_WB_Rd;
  logic              EX_MEM_regWen, MEM_WB_regWen;
  logic              branchTaken;
  logic [4:0]        stall;
  logic              nop;
  logic              flushIF;
  logic [1:0]        fwdA, fwdB;
  logic [CNT_W-1:0]  hazCount;

  modport master (
    output IF_ID_Rs, IF_ID_Rt, ID_EX_Rs, ID_EX_Rt, ID_EX_Rd, ID_EX_memRd,
           EX_MEM_Rd, MEM_WB_Rd, EX_MEM_regWen, MEM_WB_regWen, branchTaken,
    input  stall, nop, flushIF, fwdA, fwdB, hazCount
  );

  modport slave (
    input  IF_ID_Rs, IF_ID_Rt, ID_EX_Rs, ID_EX_Rt, ID_EX_Rd, ID_EX_memRd,
           EX_MEM_Rd, MEM_WB_Rd, EX_MEM_regWen, MEM_WB_regWen, branchTaken,
    output stall, nop, flushIF, fwdA, fwdB, hazCount
  );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage MIPS hazard controller: forwarding selects, load-use stall sequencer,
// branch squash, saturating stall counter. HAZ_FWD_EN enables forwarding + FSM.

// Per-operand producer match and forward select.
module hazard_fwd_lane #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic [REG_AW-1:0] ex_mem_rd,
  input  logic              ex_mem_wen,
  input  logic [REG_AW-1:0] mem_wb_rd,
  input  logic              mem_wb_wen,
  output logic              hit_mem,
  output logic              hit_wb,
  output logic [1:0]        fwd
);
  assign hit_mem = ex_mem_wen && (ex_mem_rd != '0) && (ex_mem_rd == src);
  assign hit_wb  = mem_wb_wen && (mem_wb_rd != '0) && (mem_wb_rd == src);
  // EX/MEM holds the younger result, so it wins
  assign fwd     = hit_mem ? 2'b10 : (hit_wb ? 2'b01 : 2'b00);
endmodule

module hazard_ctrl #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic          clk,
  input  logic          Rst,
  hazard_ctrl_if.slave  hif
);
  localparam int NUM_SRC = 2;

  logic [NUM_SRC-1:0][REG_AW-1:0] src;
  logic [NUM_SRC-1:0]             hit_mem, hit_wb;
  logic [NUM_SRC-1:0][1:0]        fwd;

  assign src[0] = hif.ID_EX_Rs;
  assign src[1] = hif.ID_EX_Rt;

  genvar g;
  generate
    for (g = 0; g < NUM_SRC; g++) begin : g_lane
      hazard_fwd_lane #(.REG_AW(REG_AW)) u_lane (
        .src        (src[g]),
        .ex_mem_rd  (hif.EX_MEM_Rd),
        .ex_mem_wen (hif.EX_MEM_regWen),
        .mem_wb_rd  (hif.MEM_WB_Rd),
        .mem_wb_wen (hif.MEM_WB_regWen),
        .hit_mem    (hit_mem[g]),
        .hit_wb     (hit_wb[g]),
        .fwd        (fwd[g])
      );
    end
  endgenerate

  logic [4:0] stall_c;
  logic       nop_c, flush_c;
  logic [1:0] fwda_c, fwdb_c;

`ifdef HAZ_FWD_EN
  typedef enum logic {IDLE, LDSTALL} state_t;
  localparam logic [3:0] CNT_INIT = (LOAD_LAT > 1) ? 4'(LOAD_LAT - 2) : 4'd0;

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic       load_use;

  assign load_use = hif.ID_EX_memRd && (hif.ID_EX_Rd != '0) &&
                    ((hif.ID_EX_Rd == hif.IF_ID_Rs) || (hif.ID_EX_Rd == hif.IF_ID_Rt));

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    stall_c = 5'b00000;
    nop_c   = 1'b0;
    flush_c = 1'b0;
    fwda_c  = fwd[0];
    fwdb_c  = fwd[1];
    if (hif.branchTaken) begin
      // wrong-path squash overrides any pending load-use stall
      flush_c = 1'b1;
      nop_c   = 1'b1;
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_use) begin
            stall_c = 5'b00011;
            nop_c   = 1'b1;
            if (LOAD_LAT > 1) begin
              state_n = LDSTALL;
              cnt_n   = CNT_INIT;
            end
          end
        end
        LDSTALL: begin
          stall_c = 5'b00011;
          nop_c   = 1'b1;
          if (cnt == 4'd0) state_n = IDLE;
          else             cnt_n   = cnt - 4'd1;
        end
        default: state_n = IDLE;
      endcase
    end
  end
`else
  logic unused_ld;
  assign unused_ld = ^{hif.ID_EX_memRd, hif.ID_EX_Rd, hif.IF_ID_Rs, hif.IF_ID_Rt, fwd};

  // without forwarding, any in-flight producer of an EX operand stalls the front end
  always_comb begin
    stall_c = 5'b00000;
    nop_c   = 1'b0;
    flush_c = 1'b0;
    fwda_c  = 2'b00;
    fwdb_c  = 2'b00;
    if (hif.branchTaken) begin
      flush_c = 1'b1;
      nop_c   = 1'b1;
    end else if (|{hit_mem, hit_wb}) begin
      stall_c = 5'b00111;
      nop_c   = 1'b1;
    end
  end
`endif

  // outputs are held quiet while reset is asserted
  assign hif.stall   = Rst ? stall_c : 5'b00000;
  assign hif.nop     = Rst & nop_c;
  assign hif.flushIF = Rst & flush_c;
  assign hif.fwdA    = Rst ? fwda_c : 2'b00;
  assign hif.fwdB    = Rst ? fwdb_c : 2'b00;

  logic [CNT_W-1:0] haz_cnt;

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst)                            haz_cnt <= '0;
    else if (hif.stall[0] && !(&haz_cnt)) haz_cnt <= haz_cnt + 1'b1;
  end

  assign hif.hazCount = haz_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (LOAD_LAT=3, CNT_W=4); covers both HAZ_FWD_EN builds.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic Rst = 1'b0;
  int   ntests = 0;
  int   nfail  = 0;

  hazard_ctrl_if #(.REG_AW(5), .CNT_W(4)) hif ();

  hazard_ctrl #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(4)) dut (
    .clk (clk),
    .Rst (Rst),
    .hif (hif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    hif.IF_ID_Rs = '0; hif.IF_ID_Rt = '0;
    hif.ID_EX_Rs = '0; hif.ID_EX_Rt = '0; hif.ID_EX_Rd = '0;
    hif.ID_EX_memRd = 1'b0;
    hif.EX_MEM_Rd = '0; hif.MEM_WB_Rd = '0;
    hif.EX_MEM_regWen = 1'b0; hif.MEM_WB_regWen = 1'b0;
    hif.branchTaken = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    clr();
    // hazards present while in reset
    hif.MEM_WB_Rd = 5'd4; hif.ID_EX_Rt = 5'd4; hif.MEM_WB_regWen = 1'b1;
    hif.EX_MEM_Rd = 5'd8; hif.ID_EX_Rs = 5'd8; hif.EX_MEM_regWen = 1'b1;
    hif.branchTaken = 1'b1;
    #2;
    chk("rst_stall", 32'(hif.stall), 32'h0);
    chk("rst_nop", 32'(hif.nop), 32'h0);
    chk("rst_flush", 32'(hif.flushIF), 32'h0);
    chk("rst_fwdA", 32'(hif.fwdA), 32'h0);
    chk("rst_fwdB", 32'(hif.fwdB), 32'h0);
    tick(); tick();
    chk("rst_cnt", 32'(hif.hazCount), 32'h0);
    clr();
    Rst = 1'b1;
    tick();
    chk("rel_cnt", 32'(hif.hazCount), 32'h0);
    chk("rel_stall", 32'(hif.stall), 32'h0);

`ifdef HAZ_FWD_EN
    // forwarding priority
    hif.EX_MEM_Rd = 5'd8; hif.MEM_WB_Rd = 5'd8; hif.ID_EX_Rs = 5'd8;
    hif.EX_MEM_regWen = 1'b1; hif.MEM_WB_regWen = 1'b1;
    #1 chk("fwdA_both", 32'(hif.fwdA), 32'h2);
    hif.EX_MEM_regWen = 1'b0;
    #1 chk("fwdA_wb", 32'(hif.fwdA), 32'h1);
    hif.EX_MEM_regWen = 1'b1; hif.EX_MEM_Rd = 5'd0; hif.MEM_WB_Rd = 5'd0; hif.ID_EX_Rs = 5'd0;
    #1 chk("fwdA_r0", 32'(hif.fwdA), 32'h0);
    hif.EX_MEM_Rd = 5'd3; hif.ID_EX_Rt = 5'd3;
    #1 chk("fwdB_mem", 32'(hif.fwdB), 32'h2);
    chk("fwd_nostall", 32'(hif.stall), 32'h0);
    clr();
    // load-use, three stall cycles
    hif.ID_EX_memRd = 1'b1; hif.ID_EX_Rd = 5'd9; hif.IF_ID_Rt = 5'd9;
    #1 chk("lu0_stall", 32'(hif.stall), 32'h03);
    chk("lu0_nop", 32'(hif.nop), 32'h1);
    tick(); clr();
    #1 chk("lu1_stall", 32'(hif.stall), 32'h03);
    tick();
    #1 chk("lu2_stall", 32'(hif.stall), 32'h03);
    chk("lu2_nop", 32'(hif.nop), 32'h1);
    tick();
    #1 chk("lu3_stall", 32'(hif.stall), 32'h00);
    chk("lu3_nop", 32'(hif.nop), 32'h0);
    chk("lu_cnt", 32'(hif.hazCount), 32'h3);
    // branch abort in 2nd LDSTALL cycle
    hif.ID_EX_memRd = 1'b1; hif.ID_EX_Rd = 5'd9; hif.IF_ID_Rs = 5'd9;
    tick(); clr();
    #1 chk("ba1_stall", 32'(hif.stall), 32'h03);
    tick();
    hif.branchTaken = 1'b1;
    #1 chk("ba_flush", 32'(hif.flushIF), 32'h1);
    chk("ba_nop", 32'(hif.nop), 32'h1);
    chk("ba_stall", 32'(hif.stall), 32'h0);
    tick(); clr();
    #1 chk("ba_after", 32'(hif.stall), 32'h0);
    chk("ba_cnt", 32'(hif.hazCount), 32'h5);
    // saturation via repeated load-use
    Rst = 1'b0; #1 Rst = 1'b1;
    chk("sat_clr", 32'(hif.hazCount), 32'h0);
    hif.ID_EX_memRd = 1'b1; hif.ID_EX_Rd = 5'd9; hif.IF_ID_Rt = 5'd9;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_15", 32'(hif.hazCount), 32'hF);
    tick();
    chk("sat_hold", 32'(hif.hazCount), 32'hF);
`else
    // MEM/WB producer of Rt stalls, no forwarding
    hif.MEM_WB_Rd = 5'd4; hif.ID_EX_Rt = 5'd4; hif.MEM_WB_regWen = 1'b1;
    #1 chk("wb_stall", 32'(hif.stall), 32'h07);
    chk("wb_nop", 32'(hif.nop), 32'h1);
    chk("wb_fwdB", 32'(hif.fwdB), 32'h0);
    chk("wb_flush", 32'(hif.flushIF), 32'h0);
    tick(); clr();
    chk("wb_cnt", 32'(hif.hazCount), 32'h1);
    // EX/MEM producer of Rs
    hif.EX_MEM_Rd = 5'd8; hif.ID_EX_Rs = 5'd8; hif.EX_MEM_regWen = 1'b1;
    #1 chk("mem_stall", 32'(hif.stall), 32'h07);
    chk("mem_fwdA", 32'(hif.fwdA), 32'h0);
    tick();
    chk("mem_cnt", 32'(hif.hazCount), 32'h2);
    // write enable low: no hazard
    hif.EX_MEM_regWen = 1'b0;
    #1 chk("nowen_stall", 32'(hif.stall), 32'h0);
    chk("nowen_nop", 32'(hif.nop), 32'h0);
    // r0 never matches
    hif.EX_MEM_regWen = 1'b1; hif.EX_MEM_Rd = 5'd0; hif.ID_EX_Rs = 5'd0;
    #1 chk("r0_stall", 32'(hif.stall), 32'h0);
    // differing register: no match
    hif.EX_MEM_Rd = 5'd8; hif.ID_EX_Rs = 5'd9; hif.ID_EX_Rt = 5'd24;
    #1 chk("diff_stall", 32'(hif.stall), 32'h0);
    tick();
    chk("idle_cnt", 32'(hif.hazCount), 32'h2);
    // branch beats the stall
    hif.ID_EX_Rs = 5'd8; hif.branchTaken = 1'b1;
    #1 chk("br_flush", 32'(hif.flushIF), 32'h1);
    chk("br_nop", 32'(hif.nop), 32'h1);
    chk("br_stall", 32'(hif.stall), 32'h0);
    tick(); clr();
    chk("br_cnt", 32'(hif.hazCount), 32'h2);
    // saturation
    Rst = 1'b0; #1 Rst = 1'b1;
    chk("sat_clr", 32'(hif.hazCount), 32'h0);
    hif.MEM_WB_Rd = 5'd4; hif.ID_EX_Rt = 5'd4; hif.MEM_WB_regWen = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    chk("sat_14", 32'(hif.hazCount), 32'hE);
    for (int i = 0; i < 6; i++) tick();
    chk("sat_15", 32'(hif.hazCount), 32'hF);
    tick();
    chk("sat_hold", 32'(hif.hazCount), 32'hF);
`endif
    clr();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
